// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write arbiter and its scoreboard.
package regfile_pkg;

    localparam int REGF_ADDR_W = 4;
    localparam int REGF_DATA_W = 16;

    typedef enum logic {
        ARB_WB = 1'b0,
        ARB_MD = 1'b1
    } arb_state_e;

    typedef enum logic {
        SRC_WB = 1'b0,
        SRC_MD = 1'b1
    } src_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for destinations with an outstanding mul/div result,
// with a two-port hazard lookup for the issue stage.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_i,
    input  logic [ADDR_W-1:0]    set_addr_i,
    input  logic                 clr_i,
    input  logic [ADDR_W-1:0]    clr_addr_i,
    input  logic [ADDR_W-1:0]    rd_addr1_i,
    input  logic [ADDR_W-1:0]    rd_addr2_i,
    output logic                 hazard_o,
    output logic [2**ADDR_W-1:0] busy_o
);

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a re-issue landing with the release keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hazard_o = busy_q[rd_addr1_i] | busy_q[rd_addr2_i];
    assign busy_o   = busy_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between writeback and mul/div.
// Define REGARB_AGING_EN to enable the starvation counter and the ARB_MD state.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W       = REGF_ADDR_W,
    parameter int DATA_W       = REGF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [ADDR_W-1:0]    wb_addr,
    input  logic [DATA_W-1:0]    wb_data1,
    input  logic [DATA_W-1:0]    wb_data0,
    input  logic                 md_issue,
    input  logic [ADDR_W-1:0]    md_issue_addr,
    input  logic                 md_valid,
    output logic                 md_ready,
    input  logic [ADDR_W-1:0]    md_addr,
    input  logic [DATA_W-1:0]    md_data1,
    input  logic [DATA_W-1:0]    md_data0,
    input  logic [ADDR_W-1:0]    rd_addr1,
    input  logic [ADDR_W-1:0]    rd_addr2,
    output logic                 hazard,
    output logic [2**ADDR_W-1:0] busy_vec,
    output logic                 regWrite,
    output logic [ADDR_W-1:0]    WA,
    output logic [DATA_W-1:0]    WD1,
    output logic [DATA_W-1:0]    WD0
);

    arb_state_e        state_q, state_d;
    logic              wb_hs, md_hs;
    logic              regwrite_q;
    logic [ADDR_W-1:0] wa_q;
    logic [DATA_W-1:0] wd1_q, wd0_q;
    src_e              src_q;

    // Grants are held low while reset is asserted.
    always_comb begin
        wb_ready = 1'b0;
        md_ready = 1'b0;
        if (!rst) begin
            if (state_q == ARB_MD) begin
                md_ready = md_valid;
                wb_ready = wb_valid & ~md_valid;
            end else begin
                wb_ready = wb_valid;
                md_ready = md_valid & ~wb_valid;
            end
        end
    end

    assign wb_hs = wb_valid & wb_ready;
    assign md_hs = md_valid & md_ready;

`ifdef REGARB_AGING_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The switch to ARB_MD takes effect at the edge where the counter reaches the limit.
    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        if (md_valid && !md_ready) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        case (state_q)
            ARB_WB:  if (cnt_d == CNT_MAX)       state_d = ARB_MD;
            ARB_MD:  if (md_hs || !md_valid)     state_d = ARB_WB;
            default: state_d = ARB_WB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = |STARVE_LIMIT;

    always_comb begin
        state_d = ARB_WB;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_WB;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            wa_q       <= '0;
            wd1_q      <= '0;
            wd0_q      <= '0;
            src_q      <= SRC_WB;
        end else begin
            regwrite_q <= wb_hs | md_hs;
            if (md_hs) begin
                wa_q  <= md_addr;
                wd1_q <= md_data1;
                wd0_q <= md_data0;
                src_q <= SRC_MD;
            end else if (wb_hs) begin
                wa_q  <= wb_addr;
                wd1_q <= wb_data1;
                wd0_q <= wb_data0;
                src_q <= SRC_WB;
            end
        end
    end

    assign regWrite = regwrite_q;
    assign WA       = wa_q;
    assign WD1      = wd1_q;
    assign WD0      = wd0_q;

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_i      (md_issue),
        .set_addr_i (md_issue_addr),
        .clr_i      (regwrite_q && (src_q == SRC_MD)),
        .clr_addr_i (wa_q),
        .rd_addr1_i (rd_addr1),
        .rd_addr2_i (rd_addr2),
        .hazard_o   (hazard),
        .busy_o     (busy_vec)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; expectations follow REGARB_AGING_EN.
module tb_regfile_write_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid, wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data1, wb_data0;
    logic              md_issue;
    logic [ADDR_W-1:0] md_issue_addr;
    logic              md_valid, md_ready;
    logic [ADDR_W-1:0] md_addr;
    logic [DATA_W-1:0] md_data1, md_data0;
    logic [ADDR_W-1:0] rd_addr1, rd_addr2;
    logic              hazard;
    logic [15:0]       busy_vec;
    logic              regWrite;
    logic [ADDR_W-1:0] WA;
    logic [DATA_W-1:0] WD1, WD0;

    int tests  = 0;
    int failed = 0;

    regfile_write_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_data1      (wb_data1),
        .wb_data0      (wb_data0),
        .md_issue      (md_issue),
        .md_issue_addr (md_issue_addr),
        .md_valid      (md_valid),
        .md_ready      (md_ready),
        .md_addr       (md_addr),
        .md_data1      (md_data1),
        .md_data0      (md_data0),
        .rd_addr1      (rd_addr1),
        .rd_addr2      (rd_addr2),
        .hazard        (hazard),
        .busy_vec      (busy_vec),
        .regWrite      (regWrite),
        .WA            (WA),
        .WD1           (WD1),
        .WD0           (WD0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; wb_valid = 1'b1; wb_addr = '0; wb_data1 = '0; wb_data0 = '0;
        md_issue = 1'b0; md_issue_addr = '0; md_valid = 1'b0; md_addr = '0;
        md_data1 = '0; md_data0 = '0; rd_addr1 = '0; rd_addr2 = '0;
        tick(); tick();
        check("rst_wb_ready", 32'(wb_ready), 32'd0);
        check("rst_regWrite", 32'(regWrite), 32'd0);
        check("rst_WA", 32'(WA), 32'd0);
        check("rst_WD1", 32'(WD1), 32'd0);
        check("rst_busy", 32'(busy_vec), 32'd0);
        wb_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("idle_regWrite", 32'(regWrite), 32'd0);
        check("idle_hazard", 32'(hazard), 32'd0);

        // Plain writeback write to R3.
        wb_valid = 1'b1; wb_addr = 4'd3; wb_data1 = 16'h0005; wb_data0 = 16'h0008;
        #1;
        check("wb_ready", 32'(wb_ready), 32'd1);
        check("wb_md_ready", 32'(md_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        check("wb_regWrite", 32'(regWrite), 32'd1);
        check("wb_WA", 32'(WA), 32'd3);
        check("wb_WD1", 32'(WD1), 32'h0005);
        check("wb_WD0", 32'(WD0), 32'h0008);
        tick();
        check("wb_done_regWrite", 32'(regWrite), 32'd0);
        check("wb_hold_WA", 32'(WA), 32'd3);

        // Mul/div to R10: busy, hazard, then release.
        md_issue = 1'b1; md_issue_addr = 4'd10;
        tick();
        md_issue = 1'b0;
        check("r10_busy", 32'(busy_vec), 32'h0400);
        rd_addr1 = 4'd10;
        #1;
        check("r10_hazard_p1", 32'(hazard), 32'd1);
        rd_addr1 = 4'd0; rd_addr2 = 4'd10;
        #1;
        check("r10_hazard_p2", 32'(hazard), 32'd1);
        md_valid = 1'b1; md_addr = 4'd10; md_data1 = 16'h1234; md_data0 = 16'h5678;
        #1;
        check("r10_md_ready", 32'(md_ready), 32'd1);
        tick();
        md_valid = 1'b0;
        check("r10_regWrite", 32'(regWrite), 32'd1);
        check("r10_WD1", 32'(WD1), 32'h1234);
        check("r10_hazard_N", 32'(hazard), 32'd1);
        tick();
        check("r10_busy_clr", 32'(busy_vec), 32'h0000);
        check("r10_hazard_N1", 32'(hazard), 32'd0);
        rd_addr2 = 4'd0;

        // Re-issue to R4 on the edge its mul/div write lands: set wins.
        md_issue = 1'b1; md_issue_addr = 4'd4;
        tick();
        md_issue = 1'b0;
        md_valid = 1'b1; md_addr = 4'd4;
        tick();
        md_valid = 1'b0;
        md_issue = 1'b1; md_issue_addr = 4'd4;
        tick();
        md_issue = 1'b0;
        check("r4_set_wins", 32'(busy_vec), 32'h0010);
        tick();
        check("r4_still_busy", 32'(busy_vec), 32'h0010);

        // Double issue to R5, single release; back-to-back mul/div writes.
        md_issue = 1'b1; md_issue_addr = 4'd5;
        tick(); tick();
        md_issue = 1'b0;
        check("r5_busy", 32'(busy_vec), 32'h0030);
        md_valid = 1'b1; md_addr = 4'd5;
        tick();
        md_addr = 4'd4;
        tick();
        md_valid = 1'b0;
        check("b2b_regWrite", 32'(regWrite), 32'd1);
        check("r5_released", 32'(busy_vec), 32'h0010);
        tick();
        check("r4_released", 32'(busy_vec), 32'h0000);

        // Reset while a write is latched.
        md_issue = 1'b1; md_issue_addr = 4'd9;
        tick();
        md_issue = 1'b0;
        wb_valid = 1'b1; wb_addr = 4'd1; wb_data1 = 16'hBEEF;
        tick();
        wb_valid = 1'b0;
        check("pre_rst_regWrite", 32'(regWrite), 32'd1);
        check("pre_rst_busy", 32'(busy_vec), 32'h0200);
        rst = 1'b1;
        #1;
        check("async_rst_regWrite", 32'(regWrite), 32'd0);
        check("async_rst_WA", 32'(WA), 32'd0);
        check("async_rst_WD1", 32'(WD1), 32'd0);
        check("async_rst_busy", 32'(busy_vec), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Contention: both requesters held high for six cycles.
        wb_valid = 1'b1; wb_addr = 4'd2; wb_data1 = 16'h0002;
        md_valid = 1'b1; md_addr = 4'd7; md_data1 = 16'h0007;
        #1;
        for (int i = 0; i < 6; i++) begin
            logic exp_md;
`ifdef REGARB_AGING_EN
            exp_md = (i == 4);
`else
            exp_md = 1'b0;
`endif
            check($sformatf("arb_md_ready_%0d", i), 32'(md_ready), 32'(exp_md));
            check($sformatf("arb_wb_ready_%0d", i), 32'(wb_ready), 32'(!exp_md));
            tick();
            check($sformatf("arb_WA_%0d", i), 32'(WA), exp_md ? 32'd7 : 32'd2);
            check($sformatf("arb_regWrite_%0d", i), 32'(regWrite), 32'd1);
        end
        wb_valid = 1'b0;
        #1;
        check("arb_md_after_wb_drop", 32'(md_ready), 32'd1);
        md_valid = 1'b0;
        tick();
        tick();
        check("final_regWrite", 32'(regWrite), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port (regWrite/WA/WD1/WD0) between the pipeline writeback stage and the multi-cycle multiply/divide unit, and keeps a scoreboard of destinations with a mul/div result still outstanding. It sits between writeback, the mul/div unit and the register file, and feeds a read-after-write hazard signal back to the issue stage.

## Interface
- ADDR_W, 4, register address width (16 registers)
- DATA_W, 16, register data width
- STARVE_LIMIT, 4, cycles mul/div may be blocked before it is forced ahead of writeback
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- wb_valid / wb_ready  in / out  1  writeback write request / grant
- wb_addr  in  ADDR_W  writeback destination
- wb_data1, wb_data0  in  DATA_W  writeback words
- md_issue  in  1  issue stage dispatched a mul/div this cycle
- md_issue_addr  in  ADDR_W  destination of that mul/div
- md_valid / md_ready  in / out  1  mul/div result request / grant
- md_addr  in  ADDR_W  mul/div destination
- md_data1, md_data0  in  DATA_W  mul/div result words
- rd_addr1, rd_addr2  in  ADDR_W  issue-stage read addresses (same as RR1/RR2)
- hazard  out  1  combinational; a read address is scoreboarded busy
- busy_vec  out  2**ADDR_W  scoreboard state
- regWrite  out  1  register-file write enable (registered)
- WA  out  ADDR_W  register-file write address (registered)
- WD1, WD0  out  DATA_W  register-file write words (registered)

## Operation
- At most one grant per cycle. wb_ready and md_ready are combinational from valids, arbiter state and each other.
- FSM ARB_WB (reset state): writeback wins. md_ready = md_valid & ~wb_valid.
- FSM ARB_MD: mul/div wins. wb_ready = wb_valid & ~md_valid.
- Starve counter:
  - Increments each cycle md_valid & ~md_ready; saturates at STARVE_LIMIT.
  - Clears on a mul/div handshake or when md_valid is low.
- FSM transitions:
  - ARB_WB → ARB_MD when the counter equals STARVE_LIMIT.
  - ARB_MD → ARB_WB on a mul/div handshake or when md_valid is low.
- Handshake latch: a handshake latches regWrite=1 and the winner's addr/data1/data0 into WA/WD1/WD0 at that edge. With no handshake, regWrite=0 and WA/WD hold.
- Source flag: a 1-bit source flag (SRC_WB/SRC_MD) is latched alongside the output registers.
- Scoreboard set: busy[md_issue_addr] sets at the edge where md_issue=1.
- Scoreboard clear: busy[WA] clears at the edge where regWrite=1 and the source flag is SRC_MD. This is the edge at which the register file captures the data.
- Set and clear of the same address at the same edge: set wins.
- md_issue to an already-busy address: it stays busy, and a single clear releases it.
- hazard = busy[rd_addr1] | busy[rd_addr2].
- Writeback to a busy address is passed through unchecked. The issue stage prevents it.
- Reset: regWrite=0, WA=0, WD1=0, WD0=0, busy_vec=0, counter=0, state ARB_WB, wb_ready=md_ready=0.
- Reset mid-operation: a latched write is dropped immediately and outstanding mul/div ops are forgotten.

## Timing
- Request to grant: 0 cycles (combinational ready).
- Handshake at edge N → regWrite high during cycle N..N+1 → register file updated at edge N+1.
- Busy bit falls at edge N+1, so an issue-stage read in cycle N+1 sees the new value with hazard=0.
- Forced mul/div grant occurs after at most STARVE_LIMIT+1 blocked cycles.
- Back-to-back handshakes are allowed; regWrite then stays high continuously.

## Configuration
- REGARB_AGING_EN defined: starve counter and ARB_MD state are present, as described above.
- REGARB_AGING_EN undefined: strict writeback priority. No counter, the FSM is fixed in ARB_WB, and the STARVE_LIMIT parameter is accepted but unused.

## Structure
- Package regfile_pkg:
  - ADDR_W, DATA_W defaults
  - arbiter state enum {ARB_WB, ARB_MD}
  - source enum {SRC_WB, SRC_MD}
- Sub-module reg_scoreboard:
  - holds the busy vector with set/clear ports
  - produces the hazard lookup for two read addresses

## Test plan
- Reset then idle → regWrite=0, busy_vec=0, hazard=0. Assert rst while regWrite=1 → regWrite=0 immediately.
- wb_valid=1, wb_addr=3, data1=0x0005, data0=0x0008 → wb_ready=1. Next cycle regWrite=1, WA=3, WD1=0x0005, WD0=0x0008.
- md_issue to R10, then rd_addr1=10 → hazard=1. md_valid with md_addr=10 granted at edge N → busy[10]=0 and hazard=0 from cycle N+1.
- wb_valid and md_valid both held high, aging on, STARVE_LIMIT=4 → writeback wins 4 cycles, then md granted once, then FSM returns to ARB_WB.
- Same stimulus with REGARB_AGING_EN undefined → md_ready stays 0 while wb_valid=1.
- md_issue to R4 on the same edge an SRC_MD write to R4 lands → busy[4] remains 1.
